// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word in, WIDTH bits out, with a one-entry holding register.
// Latency: first bit on dout the cycle after acceptance; back-to-back words stream with no gap.
// Backpressure: in_ready = !hold_full, so one word can queue behind the word being shifted.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             last_bit_q, last_bit_d;

    logic             accept;
    logic             at_last;
    logic             load;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The shift register holds only the bits not yet presented on dout.
    function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready = ~hold_full_q;
    assign accept   = in_valid & ~hold_full_q;
    assign at_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        last_bit_d   = last_bit_q;
        load         = 1'b0;
        load_word    = in_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    if (hold_full_q) begin
                        load        = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        dout_d       = 1'b0;
                        dout_valid_d = 1'b0;
                        last_bit_d   = 1'b0;
                    end
                end else begin
                    dout_d     = first_bit(shift_q);
                    shift_d    = drop_bit(shift_q);
                    cnt_d      = cnt_q + 1'b1;
                    last_bit_d = (cnt_d == CNT_LAST);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new word always starts at bit 0; WIDTH >= 2 so bit 0 is never the last.
        if (load) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            dout_d       = first_bit(load_word);
            shift_d      = drop_bit(load_word);
            dout_valid_d = 1'b1;
            last_bit_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_bit_q   <= last_bit_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign last_bit   = last_bit_q;
    assign busy       = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one input stream.
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct {
        bit b;
        bit last;
    } exp_bit_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;

    logic rdy_m, dout_m, dv_m, lb_m, busy_m;
    logic rdy_l, dout_l, dv_l, lb_l, busy_l;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .last_bit(lb_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .last_bit(lb_l), .busy(busy_l)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the future serial stream as a queue of bits.
    exp_bit_t qm[$];
    exp_bit_t ql[$];
    bit       cur_v, cur_dm, cur_dl, cur_last;

    logic [W-1:0] cap_m, cap_l;
    int           nvalid;

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return qm.size() < W;
    endfunction

    task automatic model_clear();
        qm.delete();
        ql.delete();
        cur_v    = 1'b0;
        cur_dm   = 1'b0;
        cur_dl   = 1'b0;
        cur_last = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] d, output bit acc);
        exp_bit_t em, el;
        acc = v && model_ready();
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back('{b: d[W-1-i], last: (i == W-1)});
                ql.push_back('{b: d[i],     last: (i == W-1)});
            end
        end
        if (qm.size() > 0) begin
            em       = qm.pop_front();
            el       = ql.pop_front();
            cur_v    = 1'b1;
            cur_dm   = em.b;
            cur_dl   = el.b;
            cur_last = em.last;
        end else begin
            cur_v    = 1'b0;
            cur_dm   = 1'b0;
            cur_dl   = 1'b0;
            cur_last = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit exp_busy;
        exp_busy = cur_v || (qm.size() >= W);
        chkb("in_ready_m", rdy_m, model_ready());
        chkb("in_ready_l", rdy_l, model_ready());
        chkb("dout_valid_m", dv_m, cur_v);
        chkb("dout_valid_l", dv_l, cur_v);
        chkb("dout_m", dout_m, cur_dm);
        chkb("dout_l", dout_l, cur_dl);
        chkb("last_bit_m", lb_m, cur_last);
        chkb("last_bit_l", lb_l, cur_last);
        chkb("busy_m", busy_m, exp_busy);
        chkb("busy_l", busy_l, exp_busy);
        if (dv_m === 1'b1) begin
            cap_m = {cap_m[W-2:0], dout_m};
            nvalid++;
        end
        if (dv_l === 1'b1) cap_l = {cap_l[W-2:0], dout_l};
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] d, output bit acc);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(v, d, acc);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), acc);
    endtask

    task automatic send_words(input logic [W-1:0] words[$]);
        bit acc;
        int idx    = 0;
        int budget = 0;
        while (idx < words.size()) begin
            cycle(1'b1, words[idx], acc);
            if (acc) idx++;
            budget++;
            if (budget > 200) begin
                chkw("send_timeout", 32'(idx), 32'(words.size()));
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chkb({tag, "_dv_m"}, dv_m, 1'b0);
        chkb({tag, "_dv_l"}, dv_l, 1'b0);
        chkb({tag, "_dout_m"}, dout_m, 1'b0);
        chkb({tag, "_dout_l"}, dout_l, 1'b0);
        chkb({tag, "_last_m"}, lb_m, 1'b0);
        chkb({tag, "_busy_m"}, busy_m, 1'b0);
        chkb({tag, "_busy_l"}, busy_l, 1'b0);
        chkb({tag, "_rdy_m"}, rdy_m, 1'b1);
        chkb({tag, "_rdy_l"}, rdy_l, 1'b1);
    endtask

    initial begin
        logic [W-1:0] words[$];
        bit acc;

        model_clear();
        cap_m  = '0;
        cap_l  = '0;
        nvalid = 0;

        // Reset state
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word E0 (first accept on first edge after release)
        cap_m  = '0;
        cap_l  = '0;
        nvalid = 0;
        cycle(1'b1, 8'hE0, acc);
        chkb("first_accept", acc, 1'b1);
        idle(10);
        chkw("e0_msb_seq", 32'(cap_m), 32'h0000_00E0);
        chkw("e0_lsb_seq", 32'(cap_l), 32'h0000_0007);
        chkw("e0_valid_bits", 32'(nvalid), 32'd8);

        // LSB-first word 07 emits 1,1,1,0,0,0,0,0
        cap_l = '0;
        cycle(1'b1, 8'h07, acc);
        idle(10);
        chkw("07_lsb_seq", 32'(cap_l), 32'h0000_00E0);

        // Back-to-back FF then 0F
        nvalid = 0;
        words  = '{8'hFF, 8'h0F};
        send_words(words);
        idle(18);
        chkw("b2b_valid_bits", 32'(nvalid), 32'd16);

        // Three words offered continuously
        nvalid = 0;
        cap_m  = '0;
        words  = '{8'h3C, 8'hA5, 8'h81};
        send_words(words);
        idle(26);
        chkw("three_valid_bits", 32'(nvalid), 32'd24);
        chkw("three_last_word", 32'(cap_m), 32'h0000_0081);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), W'($urandom), acc);
        end
        idle(20);

        // Reset mid-word with HOLD full: AA shifting, 55 held, reset at bit 4
        cycle(1'b1, 8'hAA, acc);
        cycle(1'b1, 8'h55, acc);
        idle(3);
        chkb("pre_reset_hold_full", rdy_m, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nvalid = 0;
        idle(12);
        chkw("post_reset_no_bits", 32'(nvalid), 32'd0);

        // Traffic resumes after reset
        cap_m = '0;
        cycle(1'b1, 8'h96, acc);
        chkb("post_reset_accept", acc, 1'b1);
        idle(10);
        chkw("post_reset_seq", 32'(cap_m), 32'h0000_0096);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  serial bit; drives the downstream pattern detector's din.
REQ-009 dout_valid  output  1  dout carries a word bit this cycle.
REQ-010 last_bit  output  1  one-cycle pulse coincident with the final bit of each word.
REQ-011 busy  output  1  high when the shift register or the holding register is occupied.

Function
REQ-012 Transfer: a word SHALL be accepted on any rising edge where in_valid and in_ready are both high.
REQ-013 Storage: a shift register (SHIFT) plus a one-entry holding register (HOLD).
REQ-014 in_ready SHALL equal NOT hold_full, combinationally from registered state only, with no dependence on in_valid.
REQ-015 States: IDLE (no word shifting) and SHIFT (word in progress).
REQ-016 IDLE: dout=0, dout_valid=0, last_bit=0.
REQ-017 Accept in IDLE: the word loads SHIFT directly, state goes to SHIFT, and bit 0 of the sequence appears on dout in the next cycle (latency 1).
REQ-018 SHIFT: exactly one bit per cycle, dout_valid=1, bit counter 0..WIDTH-1; counter width is $clog2(WIDTH).
REQ-019 Bit order: bit i of the sequence SHALL be in_data[WIDTH-1-i] when MSB_FIRST=1, and in_data[i] when MSB_FIRST=0.
REQ-020 last_bit SHALL be high only in the cycle where the counter equals WIDTH-1.
REQ-021 Last-bit cycle, HOLD full: HOLD moves to SHIFT, hold_full clears, and the next word starts the following cycle with no gap.
REQ-022 Last-bit cycle, HOLD empty, accept occurring: the accepted word loads SHIFT directly, with no gap and HOLD unused.
REQ-023 Last-bit cycle, HOLD empty, no accept: return to IDLE.
REQ-024 Accept in SHIFT outside the last-bit cycle: the word goes to HOLD and hold_full sets.
REQ-025 An accepted word SHALL never be dropped, duplicated or reordered.
REQ-026 in_data SHALL be sampled only at acceptance; later changes to in_data have no effect.
REQ-027 dout, dout_valid and last_bit SHALL be registered outputs.

Reset
REQ-028 While rst_n is low: state=IDLE, counter=0, hold_full=0, dout=0, dout_valid=0, last_bit=0, busy=0, in_ready=1.
REQ-029 Reset asserted mid-word SHALL abort the word immediately and discard HOLD; no partial bits are emitted after rst_n deasserts.
REQ-030 The first acceptance is possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package ser_pkg SHALL hold the state enum (IDLE, SHIFT) and the constant SER_DEFAULT_WIDTH=8.
REQ-032 The design is a single module; no sub-module is required.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, one word 8'hE0 -> dout 1,1,1,0,0,0,0,0 on cycles 1..8 after acceptance; dout_valid high on cycles 1..8; last_bit on cycle 8; then IDLE with dout=0.
REQ-034 Back-to-back words 8'hFF then 8'h0F, in_valid held high -> 16 consecutive valid bits with no gap; in_ready low from the cycle after the second accept until the HOLD handoff.
REQ-035 Three words offered continuously -> third word waits while in_ready=0 and is accepted the cycle HOLD empties; all 24 bits are emitted in order.
REQ-036 MSB_FIRST=0, word 8'h07 -> dout 1,1,1,0,0,0,0,0.
REQ-037 rst_n pulsed low at bit 4 of 8'hAA with HOLD full -> outputs 0 immediately; no further dout_valid after release until a new accept.
REQ-038 Integration with the downstream detector: word 8'hE0 -> detector dout pulses exactly once, during bit 3; idle zeros produce no pulses.
